// File: rtl/dmem_wr_capture_pkg.sv
// +------------------------------------------------------------------+
// | dmem_wr_capture_pkg: FSM state encodings and default widths      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package dmem_wr_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } cap_state_t;

  localparam int c_DATA_W     = 32;
  localparam int c_CS_W       = 4;
  localparam int c_ADDR_W     = 8;
  localparam int c_FIFO_DEPTH = 16;
  localparam int c_LEN_W      = 12;

endpackage

`default_nettype wire

// File: rtl/dmem_cap_fifo.sv
// +------------------------------------------------------------------+
// | dmem_cap_fifo: synchronous show-ahead FIFO, push accepted when   |
// | full only if a pop happens in the same cycle. Rev 1.0            |
// +------------------------------------------------------------------+
`default_nettype none

module dmem_cap_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wptr;
  logic [c_AW:0]    r_rptr;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                   (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + (c_AW+1)'(1);
      if (w_rd) r_rptr <= r_rptr + (c_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[c_AW-1:0]] <= i_data;
  end

  // Head word is forced to zero when empty so the output reads 0 after reset.
  assign o_data = o_empty ? '0 : r_mem[r_rptr[c_AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/dmem_wr_capture.sv
// +------------------------------------------------------------------+
// | dmem_wr_capture: snoops core dmem writes in a cs/address window  |
// | into a FIFO drained over valid/ready. Macro DMEM_CAP_TAG_EN adds |
// | {cs,addr} tags to each word. Rev 1.0                             |
// +------------------------------------------------------------------+
`default_nettype none

module dmem_wr_capture
  import dmem_wr_capture_pkg::*;
#(
  parameter int DATA_W     = c_DATA_W,
  parameter int CS_W       = c_CS_W,
  parameter int ADDR_W     = c_ADDR_W,
  parameter int FIFO_DEPTH = c_FIFO_DEPTH,
  parameter int LEN_W      = c_LEN_W,
`ifdef DMEM_CAP_TAG_EN
  localparam int OUT_W     = DATA_W + CS_W + ADDR_W
`else
  localparam int OUT_W     = DATA_W
`endif
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dmem_en_b,
  input  logic              dmem_rw,
  input  logic [CS_W-1:0]   dmem_cs,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdat,
  input  logic [CS_W-1:0]   cfg_cs,
  input  logic [ADDR_W-1:0] cfg_lo,
  input  logic [ADDR_W-1:0] cfg_hi,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              arm,
  input  logic              stop,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OUT_W-1:0]  m_data,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [7:0]        drop_cnt
);

  cap_state_t        r_state;
  cap_state_t        w_state_nxt;
  logic [CS_W-1:0]   r_cfg_cs;
  logic [ADDR_W-1:0] r_cfg_lo;
  logic [ADDR_W-1:0] r_cfg_hi;
  logic [LEN_W-1:0]  r_cfg_len;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_hit;
  logic [OUT_W-1:0]  r_word;
  logic              r_ovf;
  logic [7:0]        r_drop_cnt;

  logic              w_window;
  logic              w_limit;
  logic              w_accept;
  logic              w_start;
  logic              w_pop;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;
  logic [OUT_W-1:0]  w_word;

`ifdef DMEM_CAP_TAG_EN
  assign w_word = {dmem_cs, dmem_addr, dmem_wdat};
`else
  assign w_word = dmem_wdat;
`endif

  assign w_window = !dmem_en_b && !dmem_rw && (dmem_cs == r_cfg_cs) &&
                    (dmem_addr >= r_cfg_lo) && (dmem_addr <= r_cfg_hi);
  assign w_limit  = (r_cfg_len != '0) && (r_cnt == r_cfg_len);
  // Hits are counted when snooped, so dropped words still consume the length budget.
  assign w_accept = w_window && !w_limit &&
                    ((r_state == ST_ARMED) || (r_state == ST_CAPTURE));
  assign w_start  = arm && !stop && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_pop    = m_valid && m_ready;
  assign w_drop   = r_hit && w_full && !w_pop;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_start) w_state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (stop)          w_state_nxt = ST_DRAIN;
        else if (w_accept) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: if (stop || w_limit) w_state_nxt = ST_DRAIN;
      // A snooped hit still in flight must land before the FIFO can be judged empty.
      ST_DRAIN: if (w_empty && !r_hit) w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      r_state    <= ST_IDLE;
      r_cfg_cs   <= '0;
      r_cfg_lo   <= '0;
      r_cfg_hi   <= '0;
      r_cfg_len  <= '0;
      r_cnt      <= '0;
      r_hit      <= 1'b0;
      r_word     <= '0;
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hit   <= w_accept;
      if (w_accept) r_word <= w_word;
      if (w_start) begin
        r_cfg_cs   <= cfg_cs;
        r_cfg_lo   <= cfg_lo;
        r_cfg_hi   <= cfg_hi;
        r_cfg_len  <= cfg_len;
        r_cnt      <= '0;
        r_ovf      <= 1'b0;
        r_drop_cnt <= '0;
      end else begin
        if (w_accept && (r_cnt != '1)) r_cnt <= r_cnt + LEN_W'(1);
        if (w_drop) begin
          r_ovf <= 1'b1;
          if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  dmem_cap_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OUT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset_b),
    .i_push  (r_hit),
    .i_data  (r_word),
    .i_pop   (w_pop),
    .o_data  (m_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign m_valid  = !w_empty;
  assign busy     = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done     = (r_state == ST_DONE);
  assign ovf      = r_ovf;
  assign drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dmem_wr_capture.sv
// +------------------------------------------------------------------+
// | tb_dmem_wr_capture: directed vector table plus multi-cycle       |
// | sequences for dmem_wr_capture. Rev 1.0                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_dmem_wr_capture;

`ifdef DMEM_CAP_TAG_EN
  localparam int OUT_W = 44;
`else
  localparam int OUT_W = 32;
`endif

  logic             clk;
  logic             reset_b;
  logic             dmem_en_b;
  logic             dmem_rw;
  logic [3:0]       dmem_cs;
  logic [7:0]       dmem_addr;
  logic [31:0]      dmem_wdat;
  logic [3:0]       cfg_cs;
  logic [7:0]       cfg_lo;
  logic [7:0]       cfg_hi;
  logic [11:0]      cfg_len;
  logic             arm;
  logic             stop;
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [7:0]       drop_cnt;

  int n_checks;
  int n_errors;

  dmem_wr_capture u_dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .dmem_en_b (dmem_en_b),
    .dmem_rw   (dmem_rw),
    .dmem_cs   (dmem_cs),
    .dmem_addr (dmem_addr),
    .dmem_wdat (dmem_wdat),
    .cfg_cs    (cfg_cs),
    .cfg_lo    (cfg_lo),
    .cfg_hi    (cfg_hi),
    .cfg_len   (cfg_len),
    .arm       (arm),
    .stop      (stop),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cfg_cs;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [3:0]  cs;
    logic [7:0]  addr;
    logic        rw;
    logic        en_b;
    logic [31:0] wdat;
    logic        exp_cap;
  } vec_t;

  vec_t vecs[11];

  // Truncation to OUT_W leaves only the data word in the untagged build.
  function automatic logic [OUT_W-1:0] exp_word(input logic [3:0] cs, input logic [7:0] a,
                                                input logic [31:0] d);
    return OUT_W'({cs, a, d});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    dmem_en_b = 1'b1;
    dmem_rw   = 1'b1;
  endtask

  task automatic bus_wr(input logic [3:0] cs, input logic [7:0] a, input logic [31:0] d);
    dmem_cs   = cs;
    dmem_addr = a;
    dmem_wdat = d;
    dmem_en_b = 1'b0;
    dmem_rw   = 1'b0;
    tick();
  endtask

  task automatic do_arm(input logic [3:0] cs, input logic [7:0] lo, input logic [7:0] hi,
                        input logic [11:0] len);
    cfg_cs  = cs;
    cfg_lo  = lo;
    cfg_hi  = hi;
    cfg_len = len;
    arm     = 1'b1;
    tick();
    arm     = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    m_ready = 1'b1;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    m_ready = 1'b0;
    check(name, 64'(done), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_b   = 1'b1;
    dmem_en_b = 1'b1;
    dmem_rw   = 1'b1;
    dmem_cs   = '0;
    dmem_addr = '0;
    dmem_wdat = '0;
    cfg_cs    = '0;
    cfg_lo    = '0;
    cfg_hi    = '0;
    cfg_len   = '0;
    arm       = 1'b0;
    stop      = 1'b0;
    m_ready   = 1'b0;

    vecs[0]  = '{4'd2, 8'd8,  8'd11,  4'd2, 8'd8,   1'b0, 1'b0, 32'h0000_0108, 1'b1};
    vecs[1]  = '{4'd2, 8'd8,  8'd11,  4'd2, 8'd11,  1'b0, 1'b0, 32'h0000_0111, 1'b1};
    vecs[2]  = '{4'd2, 8'd8,  8'd11,  4'd2, 8'd7,   1'b0, 1'b0, 32'h0000_0107, 1'b0};
    vecs[3]  = '{4'd2, 8'd8,  8'd11,  4'd2, 8'd12,  1'b0, 1'b0, 32'h0000_0112, 1'b0};
    vecs[4]  = '{4'd2, 8'd8,  8'd11,  4'd3, 8'd9,   1'b0, 1'b0, 32'h0000_0309, 1'b0};
    vecs[5]  = '{4'd2, 8'd8,  8'd11,  4'd2, 8'd9,   1'b1, 1'b0, 32'h0000_0209, 1'b0};
    vecs[6]  = '{4'd2, 8'd8,  8'd11,  4'd2, 8'd9,   1'b0, 1'b1, 32'h0000_0219, 1'b0};
    vecs[7]  = '{4'd2, 8'd11, 8'd8,   4'd2, 8'd9,   1'b0, 1'b0, 32'h0000_0229, 1'b0};
    vecs[8]  = '{4'd5, 8'd5,  8'd5,   4'd5, 8'd5,   1'b0, 1'b0, 32'hCAFE_0005, 1'b1};
    vecs[9]  = '{4'd0, 8'd0,  8'd255, 4'd0, 8'd255, 1'b0, 1'b0, 32'h1234_5678, 1'b1};
    vecs[10] = '{4'd3, 8'd0,  8'd255, 4'd3, 8'h1F,  1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1};

    // Reset state
    tick();
    tick();
    check("rst_valid", 64'(m_valid), 64'(0));
    check("rst_data", 64'(m_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    check("rst_drop", 64'(drop_cnt), 64'(0));
    reset_b = 1'b0;
    tick();

    // Single-write vectors
    for (int i = 0; i < 11; i++) begin
      do_arm(vecs[i].cfg_cs, vecs[i].lo, vecs[i].hi, 12'd0);
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'(1));
      dmem_cs   = vecs[i].cs;
      dmem_addr = vecs[i].addr;
      dmem_wdat = vecs[i].wdat;
      dmem_rw   = vecs[i].rw;
      dmem_en_b = vecs[i].en_b;
      tick();
      bus_idle();
      tick();
      check($sformatf("vec%0d_valid", i), 64'(m_valid), 64'(vecs[i].exp_cap));
      if (vecs[i].exp_cap) begin
        check($sformatf("vec%0d_data", i), 64'(m_data),
              64'(exp_word(vecs[i].cs, vecs[i].addr, vecs[i].wdat)));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
      end
      do_stop();
      wait_done($sformatf("vec%0d_done", i));
    end

    // Window with length limit: addresses 7..12, only 8..11 captured
    do_arm(4'd2, 8'd8, 8'd11, 12'd4);
    for (int a = 7; a <= 12; a++) bus_wr(4'd2, 8'(a), 32'(a));
    bus_idle();
    tick();
    tick();
    check("win_busy", 64'(busy), 64'(1));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("win_valid%0d", i), 64'(m_valid), 64'(1));
      check($sformatf("win_data%0d", i), 64'(m_data), 64'(exp_word(4'd2, 8'(8+i), 32'(8+i))));
      m_ready = 1'b1;
      tick();
    end
    m_ready = 1'b0;
    check("win_empty", 64'(m_valid), 64'(0));
    wait_done("win_done");
    check("win_ovf", 64'(ovf), 64'(0));

    // Latency: valid exactly one cycle with m_ready held high
    do_arm(4'd2, 8'd0, 8'd255, 12'd0);
    m_ready = 1'b1;
    bus_wr(4'd2, 8'd40, 32'hA5A5_0040);
    bus_idle();
    check("lat_e", 64'(m_valid), 64'(0));
    tick();
    check("lat_e1", 64'(m_valid), 64'(1));
    check("lat_data", 64'(m_data), 64'(exp_word(4'd2, 8'd40, 32'hA5A5_0040)));
    tick();
    check("lat_e2", 64'(m_valid), 64'(0));
    m_ready = 1'b0;
    do_stop();
    wait_done("lat_done");

    // Stop in the same cycle as a hit: that hit is captured
    do_arm(4'd2, 8'd0, 8'd255, 12'd0);
    stop = 1'b1;
    bus_wr(4'd2, 8'd3, 32'h0000_5703);
    stop = 1'b0;
    bus_idle();
    tick();
    check("stophit_valid", 64'(m_valid), 64'(1));
    check("stophit_data", 64'(m_data), 64'(exp_word(4'd2, 8'd3, 32'h0000_5703)));
    wait_done("stophit_done");

    // Overflow: 20 hits into 16 entries
    do_arm(4'd2, 8'd0, 8'd255, 12'd0);
    for (int i = 0; i < 20; i++) bus_wr(4'd2, 8'(i), 32'(1000 + i));
    bus_idle();
    do_stop();
    tick();
    check("ovf_flag", 64'(ovf), 64'(1));
    check("ovf_drop", 64'(drop_cnt), 64'(4));
    check("ovf_busy", 64'(busy), 64'(1));
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovf_valid%0d", i), 64'(m_valid), 64'(1));
      check($sformatf("ovf_data%0d", i), 64'(m_data), 64'(exp_word(4'd2, 8'(i), 32'(1000 + i))));
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
    wait_done("ovf_done");
    check("ovf_sticky", 64'(ovf), 64'(1));
    check("ovf_drop_done", 64'(drop_cnt), 64'(4));

    // Full FIFO with push and pop in the same cycle: nothing dropped
    do_arm(4'd2, 8'd0, 8'd255, 12'd0);
    for (int i = 0; i < 16; i++) bus_wr(4'd2, 8'(i), 32'(100 + i));
    bus_idle();
    tick();
    tick();
    check("pp_full_valid", 64'(m_valid), 64'(1));
    bus_wr(4'd2, 8'd16, 32'd200);
    bus_idle();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("pp_ovf", 64'(ovf), 64'(0));
    check("pp_drop", 64'(drop_cnt), 64'(0));
    do_stop();
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("pp_data%0d", i), 64'(m_data),
            64'(exp_word(4'd2, 8'(i), (i < 16) ? 32'(100 + i) : 32'd200)));
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
    wait_done("pp_done");

    // Reset mid-capture with words queued and one hit in flight
    do_arm(4'd2, 8'd0, 8'd255, 12'd0);
    for (int i = 0; i < 5; i++) bus_wr(4'd2, 8'(i), 32'(50 + i));
    bus_idle();
    tick();
    tick();
    check("mid_valid", 64'(m_valid), 64'(1));
    bus_wr(4'd2, 8'd9, 32'd99);
    bus_idle();
    #2;
    reset_b = 1'b1;
    #1;
    check("mid_rst_valid", 64'(m_valid), 64'(0));
    check("mid_rst_data", 64'(m_data), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_ovf", 64'(ovf), 64'(0));
    check("mid_rst_drop", 64'(drop_cnt), 64'(0));
    tick();
    reset_b = 1'b0;
    tick();
    tick();
    tick();
    check("post_rst_valid", 64'(m_valid), 64'(0));
    check("post_rst_busy", 64'(busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
